// File: rtl/class_ovc_alloc_table_pkg.sv
// Shared helpers for the class -> output-VC allocation table.
//   log2          : ceiling log2, never below 1 (used for index widths)
//   class_width   : class index width, 1 when the table is classless
//   row_lsb       : lowest bit of row 'row' in a packed table image
package class_ovc_alloc_table_pkg;

    function automatic int unsigned log2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w++;
        end
        return w;
    endfunction

    function automatic int unsigned class_width(input int unsigned c);
        return (c > 1) ? log2(c) : 1;
    endfunction

    function automatic int unsigned row_lsb(input int unsigned row, input int unsigned v);
        return row * v;
    endfunction

endpackage

// File: rtl/class_ovc_alloc_table_ovc_rr_pick.sv
// Round-robin picker: selects the first set bit of req at or after ptr, wrapping mod V.
// Ports:
//   req  in  V   candidate vector
//   ptr  in  Pw  search start position
//   gnt  out V   one-hot pick (0 when req is empty)
//   pick out Pw  index of the pick
//   any  out 1   req had at least one bit set
module class_ovc_alloc_table_ovc_rr_pick #(
    parameter int unsigned V  = 4,
    parameter int unsigned Pw = 2
) (
    input  logic [V-1:0]  req,
    input  logic [Pw-1:0] ptr,
    output logic [V-1:0]  gnt,
    output logic [Pw-1:0] pick,
    output logic          any
);

    logic [Pw-1:0] idx;

    always_comb begin
        gnt  = '0;
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        for (int unsigned k = 0; k < V; k++) begin
            idx = Pw'((32'(ptr) + k) % V);
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                pick     = idx;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/class_ovc_alloc_table.sv
// Per-output-port class -> OVC table with busy tracking and round-robin allocation.
// Each row is a V-bit mask of OVCs the class may use; a request returns one free
// permitted OVC on the following cycle (or a fail strobe) and marks it busy.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   cfg_wr_en       write row cfg_class with cfg_mask (visible next cycle)
//   class_in        class queried / requested
//   req_valid       allocation request
//   ovc_release     per-VC release strobes
//   candidate_ovcs  comb: table[class_in] & ~busy
//   gnt_valid/gnt_ovc/gnt_fail  registered single-cycle grant result
//   ovc_busy        registered busy vector
module class_ovc_alloc_table
    import class_ovc_alloc_table_pkg::*;
#(
    parameter int unsigned     C             = 4,
    parameter int unsigned     V             = 4,
    parameter int unsigned     CVw           = (C == 0) ? V : C * V,
    parameter logic [CVw-1:0]  CLASS_SETTING = {CVw{1'b1}},
    parameter int unsigned     Cw            = class_width(C)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_wr_en,
    input  logic [Cw-1:0] cfg_class,
    input  logic [V-1:0]  cfg_mask,
    input  logic [Cw-1:0] class_in,
    input  logic          req_valid,
    input  logic [V-1:0]  ovc_release,
    output logic [V-1:0]  candidate_ovcs,
    output logic          gnt_valid,
    output logic [V-1:0]  gnt_ovc,
    output logic          gnt_fail,
    output logic [V-1:0]  ovc_busy
);

    localparam int unsigned Rows = (C > 1) ? C : 1;
    localparam int unsigned Pw   = log2(V);

    logic [V-1:0]  table_q [Rows];
    logic [Pw-1:0] ptr_q   [Rows];
    logic [V-1:0]  busy_q;

    logic [Cw-1:0] row_idx, cfg_row;
    logic          cls_ok, cfg_ok;
    logic [V-1:0]  sel_row, avail, pick_oh, grant_oh;
    logic [Pw-1:0] sel_ptr, pick_idx, ptr_next;
    logic          pick_any, grant_ok;
    logic          unused_cls;

    // Classless tables ignore the class inputs and always use row 0.
    assign unused_cls = ^{class_in, cfg_class};
    assign row_idx    = (C > 1) ? class_in : '0;
    assign cfg_row    = (C > 1) ? cfg_class : '0;
    assign cls_ok     = (C <= 1) || (32'(class_in) < C);
    assign cfg_ok     = (C <= 1) || (32'(cfg_class) < C);

    assign sel_row = table_q[row_idx];
    assign sel_ptr = ptr_q[row_idx];

    // Out-of-range classes see no permitted OVC and therefore fail.
    assign avail          = cls_ok ? (sel_row & ~busy_q) : '0;
    assign candidate_ovcs = avail;

    class_ovc_alloc_table_ovc_rr_pick #(
        .V  (V),
        .Pw (Pw)
    ) u_pick (
        .req  (avail),
        .ptr  (sel_ptr),
        .gnt  (pick_oh),
        .pick (pick_idx),
        .any  (pick_any)
    );

    assign grant_ok = req_valid & pick_any;
    assign grant_oh = req_valid ? pick_oh : '0;
    assign ptr_next = Pw'((32'(pick_idx) + 32'd1) % V);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < Rows; r++) begin
                table_q[r] <= CLASS_SETTING[row_lsb(r, V) +: V];
                ptr_q[r]   <= '0;
            end
            busy_q    <= '0;
            gnt_valid <= 1'b0;
            gnt_fail  <= 1'b0;
            gnt_ovc   <= '0;
        end else begin
            if (cfg_wr_en && cfg_ok) begin
                table_q[cfg_row] <= cfg_mask;
            end
            if (grant_ok) begin
                ptr_q[row_idx] <= ptr_next;
            end
            // The request was judged on the pre-release busy vector above.
            busy_q    <= (busy_q & ~ovc_release) | grant_oh;
            gnt_valid <= grant_ok;
            gnt_fail  <= req_valid & ~pick_any;
            gnt_ovc   <= grant_oh;
        end
    end

    assign ovc_busy = busy_q;

endmodule

// File: tb/tb_class_ovc_alloc_table.sv
module tb_class_ovc_alloc_table;

    typedef struct packed {
        logic       v;
        logic [3:0] ovc;
        logic       f;
    } resp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DUT 0: C=4, V=4, rows 0,1 = 0011, rows 2,3 = 1100
    logic       cfg_wr_en;
    logic [1:0] cfg_class;
    logic [3:0] cfg_mask;
    logic [1:0] class_in;
    logic       req_valid;
    logic [3:0] ovc_release;
    logic [3:0] candidate_ovcs;
    logic       gnt_valid;
    logic [3:0] gnt_ovc;
    logic       gnt_fail;
    logic [3:0] ovc_busy;

    // DUT 1: classless, V=4, all OVCs permitted
    logic       b_cfg_wr_en;
    logic [0:0] b_cfg_class;
    logic [3:0] b_cfg_mask;
    logic [0:0] b_class_in;
    logic       b_req_valid;
    logic [3:0] b_ovc_release;
    logic [3:0] b_candidate_ovcs;
    logic       b_gnt_valid;
    logic [3:0] b_gnt_ovc;
    logic       b_gnt_fail;
    logic [3:0] b_ovc_busy;

    class_ovc_alloc_table #(
        .C             (4),
        .V             (4),
        .CLASS_SETTING (16'hCC33)
    ) u_dut (
        .clk            (clk),
        .reset          (reset),
        .cfg_wr_en      (cfg_wr_en),
        .cfg_class      (cfg_class),
        .cfg_mask       (cfg_mask),
        .class_in       (class_in),
        .req_valid      (req_valid),
        .ovc_release    (ovc_release),
        .candidate_ovcs (candidate_ovcs),
        .gnt_valid      (gnt_valid),
        .gnt_ovc        (gnt_ovc),
        .gnt_fail       (gnt_fail),
        .ovc_busy       (ovc_busy)
    );

    class_ovc_alloc_table #(
        .C             (1),
        .V             (4),
        .CLASS_SETTING (4'hF)
    ) u_dut1 (
        .clk            (clk),
        .reset          (reset),
        .cfg_wr_en      (b_cfg_wr_en),
        .cfg_class      (b_cfg_class),
        .cfg_mask       (b_cfg_mask),
        .class_in       (b_class_in),
        .req_valid      (b_req_valid),
        .ovc_release    (b_ovc_release),
        .candidate_ovcs (b_candidate_ovcs),
        .gnt_valid      (b_gnt_valid),
        .gnt_ovc        (b_gnt_ovc),
        .gnt_fail       (b_gnt_fail),
        .ovc_busy       (b_ovc_busy)
    );

    resp_t q0[$];
    resp_t q1[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: pop an expectation whenever a DUT presents a result.
    always @(negedge clk) begin : mon0
        resp_t e;
        if (!reset && (gnt_valid || gnt_fail)) begin
            if (q0.size() == 0) begin
                check("dut0 unexpected result", {26'd0, gnt_valid, gnt_ovc, gnt_fail}, 32'd0);
            end else begin
                e = q0.pop_front();
                check("dut0 grant", {26'd0, gnt_valid, gnt_ovc, gnt_fail}, {26'd0, e});
            end
        end
    end

    always @(negedge clk) begin : mon1
        resp_t e;
        if (!reset && (b_gnt_valid || b_gnt_fail)) begin
            if (q1.size() == 0) begin
                check("dut1 unexpected result", {26'd0, b_gnt_valid, b_gnt_ovc, b_gnt_fail}, 32'd0);
            end else begin
                e = q1.pop_front();
                check("dut1 grant", {26'd0, b_gnt_valid, b_gnt_ovc, b_gnt_fail}, {26'd0, e});
            end
        end
    end

    // Advance to the next negedge with all strobes deasserted.
    task automatic idle();
        @(negedge clk);
        req_valid     = 1'b0;
        cfg_wr_en     = 1'b0;
        ovc_release   = '0;
        b_req_valid   = 1'b0;
        b_cfg_wr_en   = 1'b0;
        b_ovc_release = '0;
    endtask

    task automatic req0(input logic [1:0] cls, input resp_t e);
        idle();
        class_in  = cls;
        req_valid = 1'b1;
        q0.push_back(e);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        reset         = 1'b1;
        cfg_wr_en     = 1'b0;
        cfg_class     = '0;
        cfg_mask      = '0;
        class_in      = '0;
        req_valid     = 1'b0;
        ovc_release   = '0;
        b_cfg_wr_en   = 1'b0;
        b_cfg_class   = '0;
        b_cfg_mask    = '0;
        b_class_in    = '0;
        b_req_valid   = 1'b0;
        b_ovc_release = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset gnt_valid", 32'(gnt_valid), 32'd0);
        check("reset gnt_fail", 32'(gnt_fail), 32'd0);
        check("reset gnt_ovc", 32'(gnt_ovc), 32'd0);
        check("reset busy", 32'(ovc_busy), 32'd0);
        class_in = 2'd0;
        #1 check("reset cand cls0", 32'(candidate_ovcs), 32'h3);
        class_in = 2'd2;
        #1 check("reset cand cls2", 32'(candidate_ovcs), 32'hC);
        check("reset busy dut1", 32'(b_ovc_busy), 32'd0);
        idle();
        reset = 1'b0;

        // 1: class 0 back-to-back
        req0(2'd0, '{1'b1, 4'b0001, 1'b0});
        req0(2'd0, '{1'b1, 4'b0010, 1'b0});
        req0(2'd0, '{1'b0, 4'b0000, 1'b1});
        idle();
        check("busy after cls0", 32'(ovc_busy), 32'h3);

        // 2: release VC0 alongside a class 1 request; request sees old busy
        req0(2'd1, '{1'b0, 4'b0000, 1'b1});
        ovc_release = 4'b0001;
        #1 check("cand during release", 32'(candidate_ovcs), 32'h0);
        req0(2'd1, '{1'b1, 4'b0001, 1'b0});

        // 3: row write and request for the same class in one cycle
        req0(2'd2, '{1'b1, 4'b0100, 1'b0});
        cfg_wr_en = 1'b1;
        cfg_class = 2'd2;
        cfg_mask  = 4'b0001;
        req0(2'd2, '{1'b0, 4'b0000, 1'b1});
        idle();
        check("busy after cls2", 32'(ovc_busy), 32'h7);

        // 4: round robin on class 3; release 1000 too (not busy, no-op)
        idle();
        ovc_release = 4'b1100;
        req0(2'd3, '{1'b1, 4'b0100, 1'b0});
        idle();
        ovc_release = 4'b0100;
        req0(2'd3, '{1'b1, 4'b1000, 1'b0});
        req0(2'd3, '{1'b1, 4'b0100, 1'b0});
        idle();
        check("busy full", 32'(ovc_busy), 32'hF);

        // 5: reset pulse with a request in flight
        idle();
        class_in  = 2'd0;
        req_valid = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("midreset gnt", {29'd0, gnt_valid, gnt_fail, |gnt_ovc}, 32'd0);
        check("midreset busy", 32'(ovc_busy), 32'd0);
        class_in = 2'd2;
        #1 check("midreset row2", 32'(candidate_ovcs), 32'hC);
        idle();
        reset = 1'b0;
        idle();
        check("postreset gnt", {29'd0, gnt_valid, gnt_fail, |gnt_ovc}, 32'd0);
        req0(2'd0, '{1'b1, 4'b0001, 1'b0});

        // 6: classless table, class_in ignored
        for (int k = 0; k < 5; k++) begin
            idle();
            b_class_in  = 1'(k);
            b_req_valid = 1'b1;
            if (k < 4) q1.push_back('{1'b1, 4'(1 << k), 1'b0});
            else       q1.push_back('{1'b0, 4'b0000, 1'b1});
        end
        idle();
        idle();
        check("dut1 busy full", 32'(b_ovc_busy), 32'hF);
        check("dut0 queue drained", 32'(q0.size()), 32'd0);
        check("dut1 queue drained", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
